// File: rtl/lp_ser_pkg.sv
// lp_ser_pkg: shared types and default constants for the serializer frame loader
package lp_ser_pkg;
  typedef enum logic {TRAIN = 1'b0, RUN = 1'b1} loader_state_e;
  localparam logic [15:0] TRAIN_PATTERN_DEF = 16'hAAAA;
  localparam logic [15:0] IDLE_PATTERN_DEF = 16'h00FF;
  localparam int IDLE_CNT_W = 8;
endpackage

// File: rtl/ser_fifo.sv
// ser_fifo: synchronous FIFO, extra pointer MSB separates full from empty on wrap
module ser_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic push, pop;
  always_comb begin
    full_o = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
    empty_o = wr_q == rd_q;
    push = push_i && !full_o;
    pop = pop_i && !empty_o;
    wr_d = wr_q + {{AW{1'b0}}, push};
    rd_d = rd_q + {{AW{1'b0}}, pop};
    data_o = mem_q[rd_q[AW-1:0]];
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/ser_frame_loader.sv
// ser_frame_loader: buffers upstream words and feeds the serializer tree with
// training, payload or idle words on each enabled word-clock cycle
module ser_frame_loader
  import lp_ser_pkg::*;
#(
  parameter int               WIDTH         = 16,
  parameter int               DEPTH         = 4,
  parameter int               TRAIN_CYCLES  = 64,
  parameter logic [WIDTH-1:0] TRAIN_PATTERN = WIDTH'(TRAIN_PATTERN_DEF),
  parameter logic [WIDTH-1:0] IDLE_PATTERN  = WIDTH'(IDLE_PATTERN_DEF)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ser_en_i,
  input  logic                  retrain_i,
  input  logic [WIDTH-1:0]      data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [WIDTH-1:0]      data_o,
  output logic                  data_valid_o,
  output logic                  train_o,
  output logic [IDLE_CNT_W-1:0] idle_cnt_o
);
  localparam int CW = TRAIN_CYCLES > 1 ? $clog2(TRAIN_CYCLES) : 1;
  loader_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d, head;
  logic dv_q, dv_d, full, empty, run_en, pop, train_step, train_done;
  logic [IDLE_CNT_W-1:0] idle_q, idle_d;
  ser_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (valid_i),
    .pop_i   (pop),
    .data_i  (data_i),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );
  // retrain wins over any pop on the same edge, so the head word stays queued
  always_comb begin
    run_en = state_q == RUN && ser_en_i && !retrain_i;
    pop = run_en && !empty;
    train_step = state_q == TRAIN && ser_en_i;
    train_done = train_step && cnt_q == CW'(TRAIN_CYCLES - 1);
    state_d = retrain_i ? TRAIN : train_done ? RUN : state_q;
    cnt_d = (retrain_i || train_done) ? '0 : train_step ? cnt_q + CW'(1) : cnt_q;
    data_d = retrain_i ? TRAIN_PATTERN : run_en ? (empty ? IDLE_PATTERN : head) : data_q;
    dv_d = retrain_i ? 1'b0 : run_en ? !empty : dv_q;
    idle_d = (run_en && empty && idle_q != '1) ? idle_q + IDLE_CNT_W'(1) : idle_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= TRAIN;
      cnt_q <= '0;
      data_q <= TRAIN_PATTERN;
      dv_q <= 1'b0;
      idle_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      dv_q <= dv_d;
      idle_q <= idle_d;
    end
  end
  assign ready_o = !full;
  assign data_o = data_q;
  assign data_valid_o = dv_q;
  assign train_o = state_q == TRAIN;
  assign idle_cnt_o = idle_q;
endmodule

// File: tb/tb_ser_frame_loader.sv
// tb_ser_frame_loader: directed stimulus with a payload scoreboard and monitor
module tb_ser_frame_loader;
  logic clk = 1'b0, rst = 1'b1, ser_en = 1'b1, retrain = 1'b0, valid = 1'b0;
  logic [15:0] din = '0, dout;
  logic ready, dv, train;
  logic [7:0] idle_cnt;
  logic en_edge = 1'b0;
  logic [15:0] exp_q [$];
  int checks = 0, errors = 0, pops = 0;

  ser_frame_loader dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .ser_en_i     (ser_en),
    .retrain_i    (retrain),
    .data_i       (din),
    .valid_i      (valid),
    .ready_o      (ready),
    .data_o       (dout),
    .data_valid_o (dv),
    .train_o      (train),
    .idle_cnt_o   (idle_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  // a fresh output word exists only after an edge that was enabled and not retrained
  always @(posedge clk) en_edge <= ser_en && !retrain;

  always @(negedge clk) begin
    if (!rst && dv && en_edge) begin
      pops++;
      if (exp_q.size() == 0) chk("unexpected_word", {16'h0, dout}, 32'hDEAD_BEEF);
      else chk("word_order", {16'h0, dout}, {16'h0, exp_q.pop_front()});
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [15:0] w);
    logic acc = 1'b0;
    int t = 0;
    valid = 1'b1;
    din = w;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = ready;
      @(posedge clk);
      #1;
      t++;
    end
    valid = 1'b0;
    if (acc) exp_q.push_back(w);
    else chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_train(input int stall_at);
    int n = 0;
    for (int c = 0; c < 200 && n < 64; c++) begin
      ser_en = !(stall_at >= 0 && c >= stall_at && c < stall_at + 10);
      @(negedge clk);
      chk("train_active", {31'h0, train}, 32'd1);
      chk("train_word", {16'h0, dout}, 32'hAAAA);
      @(posedge clk);
      #1;
      if (ser_en) n++;
    end
    ser_en = 1'b1;
    @(negedge clk);
    chk("train_exit", {31'h0, train}, 32'd0);
  endtask

  initial begin
    int p0;
    logic [7:0] ic;
    cyc(2);
    chk("rst_train", {31'h0, train}, 32'd1);
    chk("rst_data", {16'h0, dout}, 32'hAAAA);
    chk("rst_dv", {31'h0, dv}, 32'd0);
    chk("rst_idle", {24'h0, idle_cnt}, 32'd0);
    chk("rst_ready", {31'h0, ready}, 32'd1);
    rst = 1'b0;
    run_train(-1);
    for (int k = 1; k <= 3; k++) begin
      cyc(1);
      @(negedge clk);
      chk("idle_word", {16'h0, dout}, 32'h00FF);
      chk("idle_count", {24'h0, idle_cnt}, k);
    end
    cyc(1);
    p0 = pops;
    push(16'h1234);
    fork
      begin
        @(negedge clk);
        chk("no_bypass", {31'h0, dv}, 32'd0);
      end
    join_none
    push(16'h5678);
    cyc(6);
    chk("burst_pops", pops - p0, 32'd2);
    @(negedge clk);
    chk("burst_idle_dv", {31'h0, dv}, 32'd0);
    chk("burst_idle_word", {16'h0, dout}, 32'h00FF);
    cyc(1);
    ser_en = 1'b0;
    ic = idle_cnt;
    push(16'h1111);
    push(16'h2222);
    push(16'h3333);
    push(16'h4444);
    @(negedge clk);
    chk("full_ready", {31'h0, ready}, 32'd0);
    chk("stall_dv", {31'h0, dv}, 32'd0);
    chk("stall_idle_hold", {24'h0, idle_cnt}, {24'h0, ic});
    cyc(1);
    fork
      push(16'h5555);
      begin
        repeat (2) @(negedge clk);
        chk("held_ready", {31'h0, ready}, 32'd0);
        @(posedge clk);
        #1;
        ser_en = 1'b1;
      end
    join
    cyc(10);
    chk("drain_empty", exp_q.size(), 32'd0);
    ser_en = 1'b0;
    push(16'hA5A5);
    push(16'h5A5A);
    ic = idle_cnt;
    ser_en = 1'b1;
    fork
      push(16'hC3C3);
      begin
        retrain = 1'b1;
        @(posedge clk);
        #1;
        retrain = 1'b0;
      end
    join
    run_train(-1);
    chk("retrain_idle_kept", {24'h0, idle_cnt}, {24'h0, ic});
    cyc(8);
    chk("retrain_drain", exp_q.size(), 32'd0);
    cyc(300);
    chk("idle_saturate", {24'h0, idle_cnt}, 32'hFF);
    ser_en = 1'b0;
    push(16'hBEEF);
    push(16'hCAFE);
    #3;
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("async_train", {31'h0, train}, 32'd1);
    chk("async_data", {16'h0, dout}, 32'hAAAA);
    chk("async_dv", {31'h0, dv}, 32'd0);
    chk("async_idle", {24'h0, idle_cnt}, 32'd0);
    chk("async_ready", {31'h0, ready}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    p0 = pops;
    run_train(20);
    cyc(1);
    @(negedge clk);
    chk("post_rst_idle", {24'h0, idle_cnt}, 32'd1);
    chk("post_rst_dv", {31'h0, dv}, 32'd0);
    cyc(5);
    chk("post_rst_discard", pops - p0, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
